// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DW_DEF / AW_DEF / CW_DEF : default data, address and counter widths
//   REG_ZERO                 : architectural zero register ($0); writes to it are dropped
//   grant_t                  : identifies which requester owns the write port
package rf_wb_arbiter_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int CW_DEF   = 16;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/rf_wb_arbiter_arb.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, reset      : clock and synchronous active-high reset
//   hold            : while high no request is acknowledged and last_grant is frozen
//   req_a, req_b    : pending requests
//   ack_a, ack_b    : combinational grant, at most one high per cycle
// last_grant resets to B so that A wins the first contention.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic req_a,
    input  logic req_b,
    output logic ack_a,
    output logic ack_b
);

    grant_t last_grant_reg;
    grant_t last_grant_next;
    logic   enable;

    assign enable = !reset && !hold;

    // Under contention the requester that did not win last time gets the port.
    always_comb begin
        ack_a = 1'b0;
        ack_b = 1'b0;
        if (enable) begin
            if (req_a && (!req_b || last_grant_reg == GRANT_B)) begin
                ack_a = 1'b1;
            end else if (req_b) begin
                ack_b = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_next = last_grant_reg;
        if (ack_a) begin
            last_grant_next = GRANT_A;
        end else if (ack_b) begin
            last_grant_next = GRANT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= GRANT_B;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port (we3/wa3/wd3) between
// an ALU writeback requester (A) and a load writeback requester (B).
//   clk, reset                  : clock and synchronous active-high reset
//   a_valid/a_addr/a_data/a_ready : requester A handshake (ready is combinational)
//   b_valid/b_addr/b_data/b_ready : requester B handshake (ready is combinational)
//   hold                        : suspends arbitration; an already registered write still commits
//   we3/wa3/wd3                 : registered register-file write port, one cycle after accept
//   a_count/b_count             : committed non-$0 writes per requester, wrapping
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          hold,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);

    logic          ack_a;
    logic          ack_b;
    logic [1:0]    commit;
    logic          we3_reg;
    logic          we3_next;
    logic [AW-1:0] wa3_reg;
    logic [AW-1:0] wa3_next;
    logic [DW-1:0] wd3_reg;
    logic [DW-1:0] wd3_next;
    logic [CW-1:0] count_reg [2];

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .req_a (a_valid),
        .req_b (b_valid),
        .ack_a (ack_a),
        .ack_b (ack_b)
    );

    assign a_ready = ack_a;
    assign b_ready = ack_b;

    // A grant to $0 is still a handshake, but it never becomes a write.
    assign commit[GRANT_A] = ack_a && (a_addr != AW'(REG_ZERO));
    assign commit[GRANT_B] = ack_b && (b_addr != AW'(REG_ZERO));

    // The output stage reloads every cycle: the reg file never stalls us.
    always_comb begin
        we3_next = commit[GRANT_A] || commit[GRANT_B];
        wa3_next = a_addr;
        wd3_next = a_data;
        if (ack_b) begin
            wa3_next = b_addr;
            wd3_next = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_reg <= 1'b0;
            wa3_reg <= '0;
            wd3_reg <= '0;
        end else begin
            we3_reg <= we3_next;
            wa3_reg <= wa3_next;
            wd3_reg <= wd3_next;
        end
    end

    // Counters advance on the same edge that loads we3 for their source.
    for (genvar gi = 0; gi < 2; gi++) begin : g_count
        always_ff @(posedge clk) begin
            if (reset) begin
                count_reg[gi] <= '0;
            end else if (commit[gi]) begin
                count_reg[gi] <= count_reg[gi] + 1'b1;
            end
        end
    end

    assign we3     = we3_reg;
    assign wa3     = wa3_reg;
    assign wd3     = wd3_reg;
    assign a_count = count_reg[GRANT_A];
    assign b_count = count_reg[GRANT_B];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Inputs change 1 time unit after a rising
// edge; combinational ready is checked on the falling edge, registered outputs
// 1 time unit after the next rising edge. A small register-file model stands in
// for reg_file downstream (it ignores writes while reset is asserted).
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid, hold;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [CW-1:0] a_count, b_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rf [32];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .hold    (hold),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .a_count (a_count),
        .b_count (b_count)
    );

    // Plain storage model; it writes even address 0 so a leaked $0 write shows up.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
    end
    always @(posedge clk) begin
        if (we3 && !reset) rf[wa3] <= wd3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2;
        tick();
        half();
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        tick();
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_a_count", 32'(a_count), 32'd0);
        chk("rst_b_count", 32'(b_count), 32'd0);

        // A only
        reset = 1'b0; b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        half();
        chk("a1_a_ready", 32'(a_ready), 32'd1);
        chk("a1_b_ready", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        chk("a1_we3", 32'(we3), 32'd1);
        chk("a1_wa3", 32'(wa3), 32'd5);
        chk("a1_wd3", wd3, 32'hDEADBEEF);
        chk("a1_a_count", 32'(a_count), 32'd1);
        tick();
        chk("a1_we3_idle", 32'(we3), 32'd0);
        chk("a1_rf5", rf[5], 32'hDEADBEEF);

        // Contention straight after reset: A first, then B
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h12345678;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hCAFEBABE;
        half();
        chk("c_a_ready", 32'(a_ready), 32'd1);
        chk("c_b_ready0", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        chk("c_we3_1", 32'(we3), 32'd1);
        chk("c_wa3_1", 32'(wa3), 32'd10);
        chk("c_wd3_1", wd3, 32'h12345678);
        half();
        chk("c_b_ready1", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        chk("c_we3_2", 32'(we3), 32'd1);
        chk("c_wa3_2", 32'(wa3), 32'd11);
        chk("c_wd3_2", wd3, 32'hCAFEBABE);
        chk("c_a_count", 32'(a_count), 32'd1);
        chk("c_b_count", 32'(b_count), 32'd1);

        // Same destination after a B grant: A then B, B's data wins
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11111111;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h22222222;
        half();
        chk("s_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        chk("s_wd3_1", wd3, 32'h11111111);
        half();
        chk("s_b_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        chk("s_wd3_2", wd3, 32'h22222222);
        tick();
        chk("s_rf5", rf[5], 32'h22222222);
        chk("s_a_count", 32'(a_count), 32'd2);
        chk("s_b_count", 32'(b_count), 32'd2);

        // Write to $0 is accepted but dropped
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        half();
        chk("z_b_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        chk("z_we3", 32'(we3), 32'd0);
        chk("z_b_count", 32'(b_count), 32'd2);
        tick();
        chk("z_rf0", rf[0], 32'd0);

        // hold after the first of four streamed writes
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h101;
        half();
        chk("h_a_ready1", 32'(a_ready), 32'd1);
        tick();
        hold = 1'b1; a_addr = 5'd2; a_data = 32'h102;
        chk("h_we3_1", 32'(we3), 32'd1);
        chk("h_wa3_1", 32'(wa3), 32'd1);
        for (int i = 0; i < 2; i++) begin
            half();
            chk("h_a_ready_held", 32'(a_ready), 32'd0);
            tick();
            chk("h_we3_held", 32'(we3), 32'd0);
        end
        hold = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            a_addr = 5'(i); a_data = 32'h100 + 32'(i);
            half();
            chk("h_a_ready_rel", 32'(a_ready), 32'd1);
            tick();
            chk("h_we3_rel", 32'(we3), 32'd1);
            chk("h_wa3_rel", 32'(wa3), 32'(i));
            chk("h_wd3_rel", wd3, 32'h100 + 32'(i));
        end
        a_valid = 1'b0;
        tick();
        chk("h_a_count", 32'(a_count), 32'd6);
        chk("h_rf4", rf[4], 32'h104);

        // Reset while the addr 7 write is sitting in the output stage
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
        half();
        chk("r_a_ready", 32'(a_ready), 32'd1);
        tick();
        reset = 1'b1; a_addr = 5'd8; a_data = 32'h88;
        chk("r_we3_pending", 32'(we3), 32'd1);
        half();
        chk("r_a_ready_rst", 32'(a_ready), 32'd0);
        tick();
        reset = 1'b0; a_valid = 1'b0;
        chk("r_we3", 32'(we3), 32'd0);
        chk("r_a_count", 32'(a_count), 32'd0);
        chk("r_b_count", 32'(b_count), 32'd0);
        tick();
        chk("r_rf7", rf[7], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
